// File: rtl/bids22_cmd_sequencer.sv
// bids22_cmd_sequencer
//   Queues host commands (opcode + payload) and feeds them one at a time to the
//   bid-master controller port. Each command is issued with a one-cycle C_start.
//   The sequencer then waits for ready, or for the timeout, and returns one
//   response per command.
//
// Ports
//   clk          rising-edge clock for all logic
//   reset_n      synchronous reset, ACTIVE-HIGH despite the name
//   cmd_valid/cmd_ready/cmd_op/cmd_data
//                host command push interface
//   flush        drop every queued command that has not been issued yet
//   C_op/C_data/C_start
//                command issue to the bid master
//   ready/err    bid master done flag and error code
//   rsp_valid/rsp_op/rsp_err/rsp_timeout
//                per-command response; the fields hold until the next response
//   busy         sequencer is not idle
//   fifo_count   queued entries, including the one in flight
module bids22_cmd_sequencer #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [DATAWIDTH-1:0]     cmd_data,
  input  logic                     flush,
  output logic [3:0]               C_op,
  output logic [DATAWIDTH-1:0]     C_data,
  output logic                     C_start,
  input  logic                     ready,
  input  logic [2:0]               err,
  output logic                     rsp_valid,
  output logic [3:0]               rsp_op,
  output logic [2:0]               rsp_err,
  output logic                     rsp_timeout,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int             AW        = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [7:0]     TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [2:0]     NOERROR   = 3'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // The reset port keeps its historical name but is active-high.
  logic srst;
  assign srst = reset_n;

  state_t                 state_reg, state_next;
  logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]            count_reg;
  logic [3:0]             op_mem   [DEPTH];
  logic [DATAWIDTH-1:0]   data_mem [DEPTH];
  logic [3:0]             cur_op_reg;
  logic [DATAWIDTH-1:0]   cur_data_reg;
  logic [7:0]             timer_reg;
  logic                   push, pop, launch, in_flight;

  // No pass-through when full: a pop in the same cycle does not open a slot.
  assign cmd_ready  = (count_reg < DEPTH_C) && !flush;
  assign push       = cmd_valid && cmd_ready;
  assign in_flight  = (state_reg != S_IDLE);
  assign busy       = in_flight;
  assign fifo_count = count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    C_start    = 1'b0;
    rsp_valid  = 1'b0;
    launch     = 1'b0;
    pop        = 1'b0;
    C_op       = '0;
    C_data     = '0;
    unique case (state_reg)
      S_IDLE: begin
        // A flush in the same cycle empties the queue, so nothing may launch.
        if ((count_reg != '0) && ready && !flush) begin
          state_next = S_ISSUE;
          launch     = 1'b1;
        end
      end
      S_ISSUE: begin
        C_start    = 1'b1;
        C_op       = cur_op_reg;
        C_data     = cur_data_reg;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        C_op   = cur_op_reg;
        C_data = cur_data_reg;
        if (ready || (timer_reg == TIMEOUT_C)) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid  = 1'b1;
        pop        = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Queue pointers and occupancy. The head stays in the queue until RESP.
  // A flush therefore keeps exactly that entry while a command is in flight.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (flush) begin
        if (in_flight) begin
          wr_ptr_reg <= rd_ptr_reg + 1'b1;
          count_reg  <= pop ? '0 : (AW+1)'(1);
        end else begin
          wr_ptr_reg <= rd_ptr_reg;
          count_reg  <= '0;
        end
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Command storage. The head is read into a register at launch.
  // That register drives C_op/C_data for the whole ISSUE/WAIT window.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_reg]   <= cmd_op;
      data_mem[wr_ptr_reg] <= cmd_data;
    end
    if (launch) begin
      cur_op_reg   <= op_mem[rd_ptr_reg];
      cur_data_reg <= data_mem[rd_ptr_reg];
    end
  end

  // The timer reads 0 during ISSUE and 1 in the first WAIT cycle.
  // It therefore matches the number of cycles elapsed since C_start.
  // Ready is tested before the timeout, so ready wins when both happen.
  always_ff @(posedge clk) begin
    if (srst) begin
      timer_reg   <= '0;
      rsp_op      <= '0;
      rsp_err     <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state_reg == S_IDLE) begin
        timer_reg <= '0;
      end else if ((state_reg == S_ISSUE) || (state_reg == S_WAIT)) begin
        timer_reg <= timer_reg + 8'd1;
      end
      if (state_reg == S_WAIT) begin
        if (ready) begin
          rsp_op      <= cur_op_reg;
          rsp_err     <= err;
          rsp_timeout <= 1'b0;
        end else if (timer_reg == TIMEOUT_C) begin
          rsp_op      <= cur_op_reg;
          rsp_err     <= NOERROR;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bids22_cmd_sequencer.sv
module tb_bids22_cmd_sequencer;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int TO    = 255;

  localparam logic [3:0] NO_OP   = 4'd0;
  localparam logic [3:0] UNLOCK  = 4'd1;
  localparam logic [3:0] LOCK    = 4'd2;
  localparam logic [3:0] LOADX   = 4'd3;
  localparam logic [2:0] NOERROR = 3'd0;
  localparam logic [2:0] BADKEY  = 3'd1;

  logic                     clk;
  logic                     reset_n;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [3:0]               cmd_op;
  logic [DW-1:0]            cmd_data;
  logic                     flush;
  logic [3:0]               C_op;
  logic [DW-1:0]            C_data;
  logic                     C_start;
  logic                     ready;
  logic [2:0]               err;
  logic                     rsp_valid;
  logic [3:0]               rsp_op;
  logic [2:0]               rsp_err;
  logic                     rsp_timeout;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_count;

  typedef struct packed {
    logic [3:0]    op;
    logic [DW-1:0] data;
  } iss_t;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] err;
    logic       to;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  iss_t mon_ie;
  rsp_t mon_re;

  int checks = 0;
  int errors = 0;

  bids22_cmd_sequencer #(
    .DATAWIDTH(DW),
    .DEPTH(DEPTH),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .flush(flush),
    .C_op(C_op),
    .C_data(C_data),
    .C_start(C_start),
    .ready(ready),
    .err(err),
    .rsp_valid(rsp_valid),
    .rsp_op(rsp_op),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor. Every issue and every response is matched in order.
  always begin
    @(posedge clk);
    #1;
    if (C_start === 1'b1) begin
      checks++;
      if (iss_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: C_op=%0d C_data=%h, no command expected", C_op, C_data);
      end else begin
        mon_ie = iss_q.pop_front();
        if ({C_op, C_data} !== {mon_ie.op, mon_ie.data}) begin
          errors++;
          $display("FAIL issue_cmd: got op=%0d data=%h, expected op=%0d data=%h",
                   C_op, C_data, mon_ie.op, mon_ie.data);
        end
      end
    end
    if (rsp_valid === 1'b1) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: op=%0d err=%0d to=%0b, no response expected",
                 rsp_op, rsp_err, rsp_timeout);
      end else begin
        mon_re = rsp_q.pop_front();
        if ({rsp_op, rsp_err, rsp_timeout} !== {mon_re.op, mon_re.err, mon_re.to}) begin
          errors++;
          $display("FAIL rsp_fields: got op=%0d err=%0d to=%0b, expected op=%0d err=%0d to=%0b",
                   rsp_op, rsp_err, rsp_timeout, mon_re.op, mon_re.err, mon_re.to);
        end
      end
    end
    $display("cycle t=%0t C_start=%0b rsp_valid=%0b count=%0d busy=%0b",
             $time, C_start, rsp_valid, fifo_count, busy);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [DW-1:0] data,
                          input logic [2:0] exp_err, input logic exp_to,
                          input bit exp_accept);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    #1;
    checks++;
    if (cmd_ready !== exp_accept) begin
      errors++;
      $display("FAIL push_ready: cmd_ready=%0b expected %0b (op=%0d)", cmd_ready, exp_accept, op);
    end
    if (exp_accept) begin
      iss_q.push_back('{op: op, data: data});
      rsp_q.push_back('{op: op, err: exp_err, to: exp_to});
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cstart(input int max, output int n);
    n = 0;
    while (C_start !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (C_start !== 1'b1) begin
      errors++;
      $display("FAIL wait_cstart: no C_start within %0d cycles", max);
    end
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_rsp: no rsp_valid within %0d cycles", max);
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (C_start !== 1'b0 || rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s: activity seen, expected no C_start/rsp_valid for %0d cycles", name, cycles);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({C_start, rsp_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: C_start/rsp_valid/busy=%b expected 000", {C_start, rsp_valid, busy});
    end
    checks++;
    if (fifo_count !== '0) begin
      errors++;
      $display("FAIL reset_count: fifo_count=%0d expected 0", fifo_count);
    end
    checks++;
    if ({C_op, C_data} !== '0) begin
      errors++;
      $display("FAIL reset_cmd: C_op=%0d C_data=%h expected 0", C_op, C_data);
    end
    checks++;
    if ({rsp_op, rsp_err, rsp_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_rsp: op=%0d err=%0d to=%0b expected 0", rsp_op, rsp_err, rsp_timeout);
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%0b expected 1", cmd_ready);
    end
  endtask

  task automatic test_single;
    ready = 1'b1;
    err   = NOERROR;
    push_cmd(LOADX, 32'h0000_0064, NOERROR, 1'b0, 1'b1);
    checks++;
    if (fifo_count !== 4'd1 || C_start !== 1'b0) begin
      errors++;
      $display("FAIL single_queued: count=%0d C_start=%0b expected 1/0", fifo_count, C_start);
    end
    tick();
    checks++;
    if (C_start !== 1'b1 || C_op !== LOADX || C_data !== 32'h64) begin
      errors++;
      $display("FAIL single_issue: C_start=%0b op=%0d data=%h expected 1/3/64", C_start, C_op, C_data);
    end
    tick();
    checks++;
    if (C_start !== 1'b0 || busy !== 1'b1 || C_op !== LOADX || C_data !== 32'h64) begin
      errors++;
      $display("FAIL single_wait: C_start=%0b busy=%0b op=%0d data=%h expected 0/1/3/64",
               C_start, busy, C_op, C_data);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: rsp_valid=%0b expected 1 four cycles after push", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || fifo_count !== 4'd0 || busy !== 1'b0 || {C_op, C_data} !== '0) begin
      errors++;
      $display("FAIL single_idle: rsp_valid=%0b count=%0d busy=%0b op=%0d expected 0/0/0/0",
               rsp_valid, fifo_count, busy, C_op);
    end
  endtask

  task automatic test_badkey_back_to_back;
    int n;
    ready = 1'b0;
    push_cmd(UNLOCK, 32'hA5A5_1234, BADKEY, 1'b0, 1'b1);
    push_cmd(LOCK, 32'h0000_0000, NOERROR, 1'b0, 1'b1);
    ready = 1'b1;
    err   = BADKEY;
    wait_cstart(5, n);
    tick();
    wait_rsp(5, n);
    err = NOERROR;
    // The push lands in the same cycle as the pop, so the count must hold at 2.
    push_cmd(NO_OP, 32'hDEAD_BEEF, NOERROR, 1'b0, 1'b1);
    checks++;
    if (fifo_count !== 4'd2) begin
      errors++;
      $display("FAIL push_pop_count: fifo_count=%0d expected 2", fifo_count);
    end
    wait_cstart(5, n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL back_to_back_gap: C_start %0d cycles after idle, expected 1", n);
    end
    tick();
    wait_rsp(5, n);
    tick();
    wait_cstart(5, n);
    tick();
    wait_rsp(5, n);
    tick();
    checks++;
    if (fifo_count !== 4'd0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL badkey_drain: count=%0d pending=%0d expected 0/0", fifo_count, rsp_q.size());
    end
  endtask

  task automatic test_fill_drain;
    int n;
    bit bad;
    ready = 1'b0;
    err   = NOERROR;
    bad   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_cmd(4'(i % 4), 32'(i * 32'h1111 + 7), NOERROR, 1'b0, 1'b1);
      if (fifo_count !== 4'(i + 1)) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL fill_count: fifo_count did not track pushes, now %0d expected %0d", fifo_count, DEPTH);
    end
    push_cmd(LOADX, 32'h9999, NOERROR, 1'b0, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (fifo_count !== 4'd8 || C_start !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL full_hold: count=%0d C_start=%0b expected 8/0", fifo_count, C_start);
    end
    ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      wait_rsp(20, n);
      if (k == 0) begin
        checks++;
        if (cmd_ready !== 1'b0 || fifo_count !== 4'd8) begin
          errors++;
          $display("FAIL full_no_passthrough: cmd_ready=%0b count=%0d expected 0/8", cmd_ready, fifo_count);
        end
      end
      tick();
    end
    checks++;
    if (fifo_count !== 4'd0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_done: count=%0d pending=%0d expected 0/0", fifo_count, rsp_q.size());
    end
  endtask

  task automatic test_timeout;
    int n;
    ready = 1'b1;
    err   = NOERROR;
    push_cmd(LOCK, 32'h0000_1234, NOERROR, 1'b1, 1'b1);
    wait_cstart(5, n);
    ready = 1'b0;
    err   = 3'd5;
    wait_rsp(300, n);
    checks++;
    if (n !== 256 || rsp_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_latency: rsp after %0d cycles to=%0b, expected 256/1", n, rsp_timeout);
    end
    tick();
    ready = 1'b1;
    err   = NOERROR;
    push_cmd(UNLOCK, 32'h0000_0055, 3'd2, 1'b0, 1'b1);
    wait_cstart(5, n);
    ready = 1'b0;
    repeat (255) tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: rsp_valid=%0b expected 0 before timer limit", rsp_valid);
    end
    ready = 1'b1;
    err   = 3'd2;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_err !== 3'd2) begin
      errors++;
      $display("FAIL ready_beats_timeout: valid=%0b to=%0b err=%0d expected 1/0/2",
               rsp_valid, rsp_timeout, rsp_err);
    end
    err = NOERROR;
    tick();
  endtask

  task automatic test_flush;
    int n;
    ready = 1'b0;
    err   = NOERROR;
    push_cmd(LOADX, 32'h10, NOERROR, 1'b0, 1'b1);
    push_cmd(LOCK, 32'h11, NOERROR, 1'b0, 1'b1);
    push_cmd(UNLOCK, 32'h12, NOERROR, 1'b0, 1'b1);
    push_cmd(NO_OP, 32'h13, NOERROR, 1'b0, 1'b1);
    push_cmd(LOADX, 32'h14, NOERROR, 1'b0, 1'b1);
    checks++;
    if (fifo_count !== 4'd5) begin
      errors++;
      $display("FAIL flush_fill: fifo_count=%0d expected 5", fifo_count);
    end
    ready = 1'b1;
    wait_cstart(5, n);
    ready = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    push_cmd(LOCK, 32'h77, NOERROR, 1'b0, 1'b0);
    flush = 1'b0;
    iss_q.delete();
    while (rsp_q.size() > 1) rsp_q.delete(rsp_q.size() - 1);
    checks++;
    if (fifo_count !== 4'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_keep_head: count=%0d busy=%0b expected 1/1", fifo_count, busy);
    end
    ready = 1'b1;
    wait_rsp(5, n);
    tick();
    checks++;
    if (fifo_count !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: count=%0d busy=%0b expected 0/0", fifo_count, busy);
    end
    check_quiet("flush_quiet", 10);
  endtask

  task automatic test_reset_mid;
    int n;
    ready = 1'b0;
    err   = NOERROR;
    push_cmd(LOCK, 32'h21, NOERROR, 1'b0, 1'b1);
    push_cmd(LOADX, 32'h22, NOERROR, 1'b0, 1'b1);
    push_cmd(UNLOCK, 32'h23, NOERROR, 1'b0, 1'b1);
    ready = 1'b1;
    wait_cstart(5, n);
    ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    iss_q.delete();
    rsp_q.delete();
    tick();
    checks++;
    if ({C_start, rsp_valid, busy} !== 3'b000 || {C_op, C_data} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: C_start/rsp_valid/busy=%b op=%0d data=%h expected 0",
               {C_start, rsp_valid, busy}, C_op, C_data);
    end
    checks++;
    if (fifo_count !== '0 || {rsp_op, rsp_err, rsp_timeout} !== '0) begin
      errors++;
      $display("FAIL midreset_state: count=%0d rsp op=%0d err=%0d to=%0b expected 0",
               fifo_count, rsp_op, rsp_err, rsp_timeout);
    end
    reset_n = 1'b0;
    ready   = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: cmd_ready=%0b expected 1", cmd_ready);
    end
    check_quiet("midreset_quiet", 10);
  endtask

  initial begin
    reset_n   = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    flush     = 1'b0;
    ready     = 1'b0;
    err       = '0;
    test_reset();
    test_single();
    test_badkey_back_to_back();
    test_fill_drain();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
